// File: rtl/uart_pkg.sv
// Shared UART receive definitions: parity modes, FSM states, oversampling constants.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int         OVS       = 16;
  localparam logic [3:0] SMP_A     = 4'd7;
  localparam logic [3:0] SMP_B     = 4'd8;
  localparam logic [3:0] SMP_C     = 4'd9;
  localparam logic [3:0] TICK_LAST = 4'(OVS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Two-of-three vote used to filter line noise around mid-bit
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every i_div+1 clocks, phase restartable.
// Latency: tick is a decode of the counter; restart makes the next tick i_div+1 clocks later.
// Backpressure: none; free-running.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_restart,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] cnt;

  // A divisor change is picked up at the very next compare
  assign o_tick = (cnt >= i_div);

  // Count up, wrap on tick, realign phase on restart
  always_ff @(posedge clk) begin
    if (reset || i_restart) begin
      cnt <= '0;
    end else if (o_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 16x oversampled, majority vote, runtime parity/stop, one-word holding register.
// Latency: word appears one clock after mid-sample of the final stop bit.
// Backpressure: o_valid/i_ready; a word completing while the register is full is dropped and o_overrun set.
// Optional: UART_RX_BREAK_DETECT_EN enables break detection on o_break.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DBIT  = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] i_div,
  input  logic [1:0]       i_parity_mode,
  input  logic             i_two_stop,
  input  logic             rx,
  output logic [DBIT-1:0]  o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_parity_err,
  output logic             o_frame_err,
  output logic             o_overrun,
  input  logic             i_clr_err,
  output logic             o_busy,
  output logic             o_break
);

`ifdef UART_RX_BREAK_DETECT_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  logic            rx_s1, rx_s2, rx_d;
  rx_state_t       state;
  logic [3:0]      s_cnt;
  logic [3:0]      bit_idx;
  logic            smp_a, smp_b;
  logic [DBIT-1:0] shreg;
  logic [1:0]      mode_l;
  logic            two_l;
  logic            stop_idx;
  logic            perr, ferr;
  logic            all_zero;
  logic            brk_wait;
  logic            tick;

  logic start_det, maj, has_par, par_bad, at_dec, at_end, brk_hit, cmpl;

  assign start_det = (state == IDLE) && rx_d && !rx_s2;
  assign maj       = maj3(smp_a, smp_b, rx_s2);
  assign has_par   = (mode_l == PAR_EVEN) || (mode_l == PAR_ODD);
  assign par_bad   = (^shreg) ^ maj ^ (mode_l == PAR_ODD);
  assign at_dec    = tick && (s_cnt == SMP_C);
  assign at_end    = tick && (s_cnt == TICK_LAST);
  assign brk_hit   = BRK_EN && all_zero && !stop_idx && !maj;
  assign cmpl      = (state == STOP) && !brk_wait && at_dec && (stop_idx == two_l) && !brk_hit;
  assign o_busy    = (state != IDLE);

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .i_restart (start_det),
    .i_div     (i_div),
    .o_tick    (tick)
  );

  // Two-flop synchroniser plus one history flop for falling-edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // Frame FSM with holding register, error flags and break handling
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      s_cnt        <= '0;
      bit_idx      <= '0;
      smp_a        <= 1'b1;
      smp_b        <= 1'b1;
      shreg        <= '0;
      mode_l       <= PAR_NONE;
      two_l        <= 1'b0;
      stop_idx     <= 1'b0;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      all_zero     <= 1'b0;
      brk_wait     <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
      o_break      <= 1'b0;
    end else begin
      o_break <= 1'b0;
      if (o_valid && i_ready) o_valid <= 1'b0;
      if (i_clr_err) o_overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (start_det) begin
            state    <= START;
            s_cnt    <= '0;
            bit_idx  <= '0;
            mode_l   <= i_parity_mode;
            two_l    <= i_two_stop;
            stop_idx <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            all_zero <= 1'b1;
            brk_wait <= 1'b0;
          end
        end
        default: begin
          if (brk_wait) begin
            // Line held low after a break: wait for idle level before rearming
            if (rx_s2) begin
              state    <= IDLE;
              brk_wait <= 1'b0;
            end
          end else if (tick) begin
            if (s_cnt == SMP_A) smp_a <= rx_s2;
            if (s_cnt == SMP_B) smp_b <= rx_s2;
            s_cnt <= s_cnt + 4'd1;
            case (state)
              START: begin
                if (at_dec && maj) state <= IDLE;
                else if (at_end)   state <= DATA;
              end
              DATA: begin
                if (at_dec) begin
                  shreg <= {maj, shreg[DBIT-1:1]};
                  if (maj) all_zero <= 1'b0;
                end
                if (at_end) begin
                  if (bit_idx == 4'(DBIT - 1)) state <= has_par ? PARITY : STOP;
                  else bit_idx <= bit_idx + 4'd1;
                end
              end
              PARITY: begin
                if (at_dec) begin
                  perr <= par_bad;
                  if (maj) all_zero <= 1'b0;
                end
                if (at_end) state <= STOP;
              end
              STOP: begin
                if (at_dec) begin
                  if (!maj) ferr <= 1'b1;
                  if (brk_hit) begin
                    o_break  <= 1'b1;
                    brk_wait <= 1'b1;
                  end
                end
                if (at_end) stop_idx <= 1'b1;
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase

      // Completion overrides the handshake clear; a full register drops the word
      if (cmpl) begin
        state <= IDLE;
        if (!o_valid || i_ready) begin
          o_data       <= shreg;
          o_parity_err <= perr;
          o_frame_err  <= ferr | !maj;
          o_valid      <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: scoreboard of expected words popped on each handshake.
// Latency: n/a.
// Backpressure: exercised through i_ready.
module tb_uart_rx_cfg;

  typedef struct packed {
    logic [7:0] dat;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] i_div = 16'd0;
  logic [1:0]  i_parity_mode = 2'b00;
  logic        i_two_stop = 1'b0;
  logic        rx = 1'b1;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic        o_parity_err;
  logic        o_frame_err;
  logic        o_overrun;
  logic        i_clr_err = 1'b0;
  logic        o_busy;
  logic        o_break;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   bt      = 16;
  int   vld_cycles = 0;
  int   brk_cycles = 0;
  exp_t exp_q[$];

  uart_rx_cfg #(.DBIT(8), .DIV_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_div         (i_div),
    .i_parity_mode (i_parity_mode),
    .i_two_stop    (i_two_stop),
    .rx            (rx),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_parity_err  (o_parity_err),
    .o_frame_err   (o_frame_err),
    .o_overrun     (o_overrun),
    .i_clr_err     (i_clr_err),
    .o_busy        (o_busy),
    .o_break       (o_break)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: outputs sampled on the falling edge, inputs change just after the rising edge
  always @(negedge clk) begin
    if (!reset) begin
      if (o_valid) vld_cycles++;
      if (o_break) brk_cycles++;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {24'd0, o_data}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("data", {24'd0, o_data}, {24'd0, e.dat});
          chk("parity_err", {31'd0, o_parity_err}, {31'd0, e.perr});
          chk("frame_err", {31'd0, o_frame_err}, {31'd0, e.ferr});
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    wait_clk(bt);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par_v,
                            input logic s1, input logic two, input logic s2);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (has_par) send_bit(par_v);
    send_bit(s1);
    if (two) send_bit(s2);
    rx = 1'b1;
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.dat  = d;
    e.perr = pe;
    e.ferr = fe;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      wait_clk(1);
      k++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_v, base_b;

    // Reset state
    wait_clk(5);
    chk("rst_valid",   {31'd0, o_valid},      0);
    chk("rst_data",    {24'd0, o_data},       0);
    chk("rst_perr",    {31'd0, o_parity_err}, 0);
    chk("rst_ferr",    {31'd0, o_frame_err},  0);
    chk("rst_overrun", {31'd0, o_overrun},    0);
    chk("rst_busy",    {31'd0, o_busy},       0);
    chk("rst_break",   {31'd0, o_break},      0);
    reset = 1'b0;
    wait_clk(10);

    // 8N1 0x55: single-cycle valid with ready high
    base_v = vld_cycles;
    push(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_clk(8);
    drain("8n1_drain");
    chk("8n1_valid_pulse", vld_cycles - base_v, 1);
    chk("8n1_valid_low", {31'd0, o_valid}, 0);

    // Parity: even with wrong bit, even with right bit, odd with right bit
    i_parity_mode = 2'b01;
    push(8'hA3, 1'b1, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_clk(8);
    push(8'hA3, 1'b0, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_clk(8);
    i_parity_mode = 2'b10;
    push(8'hA3, 1'b0, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_clk(8);
    drain("parity_drain");
    i_parity_mode = 2'b00;

    // 8N2 with bad second stop bit
    i_two_stop = 1'b1;
    push(8'h3C, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_clk(8);
    drain("8n2_drain");
    i_two_stop = 1'b0;

    // Short low glitch: false start, no word
    base_v = vld_cycles;
    rx = 1'b0;
    wait_clk(3);
    rx = 1'b1;
    wait_clk(3);
    chk("glitch_busy", {31'd0, o_busy}, 1);
    wait_clk(25);
    chk("glitch_idle", {31'd0, o_busy}, 0);
    chk("glitch_no_word", vld_cycles - base_v, 0);

    // Overrun: second word dropped while the first is held
    i_ready = 1'b0;
    push(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_clk(4);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_clk(8);
    chk("ovr_valid",   {31'd0, o_valid},   1);
    chk("ovr_data",    {24'd0, o_data},    32'h11);
    chk("ovr_flag",    {31'd0, o_overrun}, 1);
    i_ready = 1'b1;
    wait_clk(2);
    chk("ovr_valid_drop", {31'd0, o_valid},   0);
    chk("ovr_sticky",     {31'd0, o_overrun}, 1);
    i_clr_err = 1'b1;
    wait_clk(1);
    i_clr_err = 1'b0;
    chk("ovr_cleared", {31'd0, o_overrun}, 0);
    drain("ovr_drain");

    // Back-to-back frames at a slower divisor, then reset mid-frame
    i_div = 16'd4;
    bt = 80;
    wait_clk(10);
    push(8'h01, 1'b0, 1'b0);
    push(8'hFE, 1'b0, 1'b0);
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_clk(20);
    drain("b2b_drain");
    base_v = vld_cycles;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    wait_clk(bt / 2);
    reset = 1'b1;
    rx = 1'b1;
    wait_clk(3);
    chk("midrst_valid", {31'd0, o_valid}, 0);
    chk("midrst_busy",  {31'd0, o_busy},  0);
    reset = 1'b0;
    wait_clk(1200);
    chk("midrst_no_word", vld_cycles - base_v, 0);
    chk("midrst_queue", exp_q.size(), 0);

    // Long low line: break or zero word with framing error
    i_div = 16'd0;
    bt = 16;
    wait_clk(10);
    base_v = vld_cycles;
    base_b = brk_cycles;
`ifdef UART_RX_BREAK_DETECT_EN
    rx = 1'b0;
    wait_clk(12 * 16);
    rx = 1'b1;
    wait_clk(40);
    chk("break_pulse", brk_cycles - base_b, 1);
    chk("break_no_word", vld_cycles - base_v, 0);
    chk("break_idle", {31'd0, o_busy}, 0);
`else
    push(8'h00, 1'b0, 1'b1);
    rx = 1'b0;
    wait_clk(12 * 16);
    rx = 1'b1;
    wait_clk(40);
    drain("break_word_drain");
    chk("break_tied_low", brk_cycles - base_b, 0);
    chk("break_one_word", vld_cycles - base_v, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
